// File: rtl/digit_ram_fifo_ctrl_if.sv
// rtl/digit_ram_fifo_ctrl_if.sv - producer/consumer handshake and RAM port bundle for the digit FIFO controller
interface digit_ram_fifo_ctrl_if #(
   parameter int DATA_WIDTH = 2,
   parameter int ADDR_WIDTH = 7
);
   logic                  flush;
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_digit;
   logic                  in_ready;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_digit;
   logic                  out_ready;
   logic [ADDR_WIDTH:0]   level;
   logic                  clearing;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_write_addr;
   logic [DATA_WIDTH-1:0] ram_data;
   logic [ADDR_WIDTH-1:0] ram_read_addr;
   logic [DATA_WIDTH-1:0] ram_q;

   modport master (
      output flush, in_valid, in_digit, out_ready, ram_q,
      input  in_ready, out_valid, out_digit, level, clearing,
             ram_we, ram_write_addr, ram_data, ram_read_addr
   );

   modport slave (
      input  flush, in_valid, in_digit, out_ready, ram_q,
      output in_ready, out_valid, out_digit, level, clearing,
             ram_we, ram_write_addr, ram_data, ram_read_addr
   );
endinterface

// File: rtl/digit_ram_fifo_ctrl.sv
// rtl/digit_ram_fifo_ctrl.sv - circular FIFO controller over a registered-read digit RAM with post-reset zero sweep
module digit_ram_fifo_ctrl #(
   parameter int DATA_WIDTH     = 2,
   parameter int ADDR_WIDTH     = 7,
   parameter int CLEAR_ON_RESET = 1
) (
   input logic                  clk,
   input logic                  rst_n,
   digit_ram_fifo_ctrl_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   LEVEL_FULL = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
   logic [ADDR_WIDTH:0]   level_q, level_d;

   logic                  run;
   logic                  in_ready;
   logic                  out_valid;
   logic                  push;
   logic                  pop;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_write_addr;
   logic [DATA_WIDTH-1:0] ram_data;
   logic [ADDR_WIDTH-1:0] ram_read_addr;

   always_comb begin
      run            = (state_q == ST_RUN);
      in_ready       = rst_n & run & (level_q != LEVEL_FULL);
      out_valid      = rst_n & run & (level_q != '0);
      push           = bus.in_valid & in_ready;
      pop            = out_valid & bus.out_ready;
      ram_we         = 1'b0;
      ram_write_addr = wr_ptr_q;
      ram_data       = bus.in_digit;
      ram_read_addr  = '0;

      if (!run) begin
         ram_we         = rst_n;
         ram_write_addr = clr_ptr_q;
         ram_data       = '0;
      end else if (!bus.flush) begin
         // A flushed push must not touch RAM; a flushed read restarts at address 0.
         ram_we        = push;
         ram_read_addr = rst_n ? (rd_ptr_q + ADDR_WIDTH'(pop)) : '0;
      end
   end

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      clr_ptr_d = clr_ptr_q;
      level_d   = level_q;

      if (!run) begin
         clr_ptr_d = clr_ptr_q + 1'b1;
         if (clr_ptr_q == LAST_ADDR) begin
            state_d = ST_RUN;
         end
      end else if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      level_d = level_q + 1'b1;
         else if (pop && !push) level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         clr_ptr_q <= '0;
         level_q   <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         clr_ptr_q <= clr_ptr_d;
         level_q   <= level_d;
      end
   end

   assign bus.in_ready       = in_ready;
   assign bus.out_valid      = out_valid;
   assign bus.out_digit      = bus.ram_q;
   assign bus.level          = level_q;
   assign bus.clearing       = rst_n & ~run;
   assign bus.ram_we         = ram_we;
   assign bus.ram_write_addr = ram_write_addr;
   assign bus.ram_data       = ram_data;
   assign bus.ram_read_addr  = ram_read_addr;
endmodule

// File: tb/tb_digit_ram_fifo_ctrl.sv
// tb/tb_digit_ram_fifo_ctrl.sv - directed self-checking bench for digit_ram_fifo_ctrl with a behavioural digit RAM
module tb_digit_ram_fifo_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;
   int   wr_idx = 0;
   int   rd_idx = 0;
   int   order_errs = 0;

   always #5 clk = ~clk;

   digit_ram_fifo_ctrl_if #(.DATA_WIDTH(2), .ADDR_WIDTH(7)) bus ();

   digit_ram_fifo_ctrl #(.DATA_WIDTH(2), .ADDR_WIDTH(7), .CLEAR_ON_RESET(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // RAM model: one write port, read address registered, asynchronous read of the registered address
   logic [1:0] mem [128];
   logic [6:0] ra_q = '0;
   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_write_addr] <= bus.ram_data;
      ra_q <= bus.ram_read_addr;
   end
   assign bus.ram_q = mem[ra_q];

   task automatic check_eq(input string tag, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic logic [1:0] dig(input int k);
      return 2'((k ^ (k >> 2)) & 3);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One handshake cycle with digit bookkeeping kept by the bench
   task automatic cycle(input bit pv, input bit pr);
      bus.flush     = 1'b0;
      bus.in_valid  = pv;
      bus.in_digit  = dig(wr_idx);
      bus.out_ready = pr;
      #1;
      if (bus.out_valid && pr) begin
         if (bus.out_digit !== dig(rd_idx)) order_errs++;
         rd_idx++;
      end
      if (pv && bus.in_ready) wr_idx++;
      tick();
   endtask

   task automatic sweep(input string tag);
      int n = 0;
      int errs = 0;
      int nz = 0;
      while (bus.clearing && n < 300) begin
         if (bus.ram_we !== 1'b1 || int'(bus.ram_write_addr) != (n % 128) || bus.ram_data !== 2'b00) errs++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) errs++;
         n++;
         tick();
      end
      check_eq({tag, "_cycles"}, n, 128);
      check_eq({tag, "_errs"}, errs, 0);
      for (int i = 0; i < 128; i++) if (mem[i] != 2'b00) nz++;
      check_eq({tag, "_ram_zero"}, nz, 0);
      check_eq({tag, "_level"}, int'(bus.level), 0);
      check_eq({tag, "_in_ready"}, int'(bus.in_ready), 1);
      check_eq({tag, "_out_valid"}, int'(bus.out_valid), 0);
   endtask

   initial begin
      int guard;
      int lvl_errs;
      for (int i = 0; i < 128; i++) mem[i] = 2'b11;
      rst_n = 1'b0;
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_digit = 2'b00; bus.out_ready = 1'b0;
      tick(); tick();
      check_eq("rst_in_ready", int'(bus.in_ready), 0);
      check_eq("rst_out_valid", int'(bus.out_valid), 0);
      check_eq("rst_ram_we", int'(bus.ram_we), 0);
      check_eq("rst_level", int'(bus.level), 0);
      rst_n = 1'b1;
      #1;
      sweep("sweep1");

      // Three digits, held, then drained
      bus.in_valid = 1'b1;
      bus.in_digit = 2'b01; tick();
      bus.in_digit = 2'b11; tick();
      bus.in_digit = 2'b10; tick();
      bus.in_valid = 1'b0; #1;
      check_eq("three_level", int'(bus.level), 3);
      check_eq("three_head", int'(bus.out_digit), 1);
      bus.out_ready = 1'b1; #1;
      check_eq("pop0", int'(bus.out_digit), 1);
      check_eq("pop0_valid", int'(bus.out_valid), 1);
      tick();
      check_eq("pop1", int'(bus.out_digit), 3);
      tick();
      check_eq("pop2", int'(bus.out_digit), 2);
      tick();
      check_eq("three_empty", int'(bus.out_valid), 0);
      bus.out_ready = 1'b0;

      // Fill to full, push+pop while full, drain, then stream across the wrap
      for (int i = 0; i < 128; i++) cycle(1'b1, 1'b0);
      check_eq("full_level", int'(bus.level), 128);
      check_eq("full_in_ready", int'(bus.in_ready), 0);
      bus.in_valid = 1'b1; bus.out_ready = 1'b1; #1;
      check_eq("full_no_write", int'(bus.ram_we), 0);
      cycle(1'b1, 1'b1);
      check_eq("full_pushpop_level", int'(bus.level), 127);
      guard = 0;
      while (bus.out_valid && guard < 200) begin cycle(1'b0, 1'b1); guard++; end
      check_eq("drain_count", rd_idx, 128);
      check_eq("drain_wr_idx", wr_idx, 128);
      guard = 0;
      while (rd_idx < 328 && guard < 1000) begin cycle(wr_idx < 328, 1'b1); guard++; end
      check_eq("stream_count", rd_idx, 328);
      check_eq("stream_order", order_errs, 0);

      // Steady level 5 with simultaneous push and pop
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
      check_eq("l5_level", int'(bus.level), 5);
      check_eq("l5_stable_head", int'(bus.out_digit), int'(dig(rd_idx)));
      lvl_errs = 0;
      for (int i = 0; i < 300; i++) begin
         cycle(1'b1, 1'b1);
         if (bus.level != 8'd5) lvl_errs++;
      end
      check_eq("l5_level_errs", lvl_errs, 0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
      check_eq("l5_drained", int'(bus.out_valid), 0);
      check_eq("l5_order", order_errs, 0);

      // Flush at level 40 with a push pending
      for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0);
      check_eq("fl_level40", int'(bus.level), 40);
      bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_digit = 2'b11; bus.out_ready = 1'b1; #1;
      check_eq("fl_ram_we", int'(bus.ram_we), 0);
      check_eq("fl_read_addr", int'(bus.ram_read_addr), 0);
      tick();
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; #1;
      check_eq("fl_level", int'(bus.level), 0);
      check_eq("fl_out_valid", int'(bus.out_valid), 0);
      rd_idx = wr_idx;
      cycle(1'b1, 1'b0);
      check_eq("fl_next_valid", int'(bus.out_valid), 1);
      check_eq("fl_next_digit", int'(bus.out_digit), int'(dig(rd_idx)));
      cycle(1'b0, 1'b1);
      check_eq("fl_next_level", int'(bus.level), 0);

      // Reset pulse at level 60 restarts the sweep
      for (int i = 0; i < 60; i++) cycle(1'b1, 1'b0);
      check_eq("rs_level60", int'(bus.level), 60);
      bus.in_valid = 1'b0;
      rst_n = 1'b0; #1;
      check_eq("rs_out_valid", int'(bus.out_valid), 0);
      check_eq("rs_in_ready", int'(bus.in_ready), 0);
      tick();
      rst_n = 1'b1; #1;
      sweep("sweep2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
